// File: rtl/mul_div_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO; done MUL_LAT+1 cycles after a
// multiply, 34 after a divide. stall_o freezes the pipeline while busy; start is ignored outside IDLE.
module mul_div_ctrl #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] opA;       // multiplicand, or dividend shifting out / quotient shifting in
    logic [31:0] opB;       // multiplier, or divisor magnitude
    logic [31:0] rem;
    logic        mulSigned;
    logic        negQ;
    logic        negR;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        doneReg;

    logic        accept;
    logic        isMul;
    logic        isDiv;
    logic        divZero;
    logic        divSigned;
    logic [63:0] prod;
    logic [32:0] remShift;
    logic [32:0] remDiff;
    logic        remGeq;
    logic [31:0] remNext;
    logic [31:0] quoNext;

    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        isMul     = (op == OP_MULT) || (op == OP_MULTU);
        isDiv     = (op == OP_DIV) || (op == OP_DIVU);
        divZero   = (num2 == 32'd0);
        divSigned = (op == OP_DIV);
    end

    assign stall_o = (accept && (isMul || (isDiv && !divZero))) || (state != IDLE);
    assign busy    = (state != IDLE);
    assign done    = doneReg;
    assign hi_o    = hiReg;
    assign lo_o    = loReg;

    // Sign-extending to 64 bits makes the truncated unsigned product equal the signed one.
    always_comb begin
        if (mulSigned)
            prod = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
        else
            prod = {32'd0, opA} * {32'd0, opB};
    end

    // Restoring step: the borrow out of the 33-bit subtraction is the inverted quotient bit.
    always_comb begin
        remShift = {rem, opA[31]};
        remDiff  = remShift - {1'b0, opB};
        remGeq   = !remDiff[32];
        remNext  = remGeq ? remDiff[31:0] : remShift[31:0];
        quoNext  = {opA[30:0], remGeq};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            opA       <= 32'd0;
            opB       <= 32'd0;
            rem       <= 32'd0;
            mulSigned <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            hiReg     <= 32'd0;
            loReg     <= 32'd0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MTHI: hiReg <= num1;
                                OP_MTLO: loReg <= num1;
                                OP_MULT, OP_MULTU: begin
                                    opA       <= num1;
                                    opB       <= num2;
                                    mulSigned <= (op == OP_MULT);
                                    cnt       <= 8'(MUL_LAT);
                                    state     <= MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    // Back-to-back divide-by-zero ops must not stretch done.
                                    if (divZero) begin
                                        doneReg <= !doneReg;
                                    end else begin
                                        opA   <= (divSigned && num1[31]) ? -num1 : num1;
                                        opB   <= (divSigned && num2[31]) ? -num2 : num2;
                                        rem   <= 32'd0;
                                        negQ  <= divSigned && (num1[31] ^ num2[31]);
                                        negR  <= divSigned && num1[31];
                                        cnt   <= 8'(DIV_ITER);
                                        state <= DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt == 8'd1) begin
                            hiReg   <= prod[63:32];
                            loReg   <= prod[31:0];
                            cnt     <= 8'd0;
                            doneReg <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    DIV: begin
                        opA <= quoNext;
                        rem <= remNext;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1)
                            state <= FIX;
                    end
                    FIX: begin
                        loReg   <= negQ ? -opA : opA;
                        hiReg   <= negR ? -rem : rem;
                        doneReg <= 1'b1;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
